// File: rtl/stopwatch_display.sv
// Four-digit multiplexed seven-segment driver for an MM.SS stopwatch.
// Each scan frame shows a coherent time snapshot; adjust mode flashes the selected digit pair.
module stopwatch_display #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_blink,
   input  logic       adj,
   input  logic       sel,
   input  logic [3:0] min_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] sec_ones,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       dp
);

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic [1:0]       idx_reg;
   logic [1:0]       idx_next;
   logic             tc;
   logic             frame_end;
   logic             blink_q_reg;

   logic [3:0]       digit_in [4];
   logic [3:0]       snap     [4];

   logic             blank;
   logic [3:0]       cur_digit;
   logic [6:0]       seg_reg;
   logic [6:0]       seg_next;
   logic [3:0]       an_reg;
   logic [3:0]       an_next;
   logic             dp_reg;
   logic             dp_next;

   assign digit_in[0] = sec_ones;
   assign digit_in[1] = sec_tens;
   assign digit_in[2] = min_ones;
   assign digit_in[3] = min_tens;

   assign tc        = (cnt_reg == CNT_W'(REFRESH_DIV - 1));
   assign frame_end = tc && (idx_reg == 2'd3);

   always_comb begin
      cnt_next = tc ? '0 : cnt_reg + 1'b1;
      idx_next = tc ? idx_reg + 2'd1 : idx_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg     <= '0;
         idx_reg     <= 2'd0;
         blink_q_reg <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         idx_reg     <= idx_next;
         blink_q_reg <= clk_blink;
      end
   end

   // Digits are latched only at the end of a frame so a frame never mixes two time values.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_snap
         logic [3:0] digit_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               digit_reg <= 4'd0;
            end else if (frame_end) begin
               digit_reg <= digit_in[gi];
            end
         end

         assign snap[gi] = digit_reg;
      end
   endgenerate

   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] pattern;
      case (bcd)
         4'd0:    pattern = 7'h40;
         4'd1:    pattern = 7'h79;
         4'd2:    pattern = 7'h24;
         4'd3:    pattern = 7'h30;
         4'd4:    pattern = 7'h19;
         4'd5:    pattern = 7'h12;
         4'd6:    pattern = 7'h02;
         4'd7:    pattern = 7'h78;
         4'd8:    pattern = 7'h00;
         4'd9:    pattern = 7'h10;
         default: pattern = 7'h3F;
      endcase
      return pattern;
   endfunction

   // idx[1] splits the scan into the seconds pair (0) and the minutes pair (1).
   always_comb begin
      cur_digit = snap[idx_reg];
      blank     = adj && blink_q_reg && (sel ? idx_reg[1] : ~idx_reg[1]);
      an_next   = blank ? 4'hF : ~(4'b0001 << idx_reg);
      seg_next  = blank ? 7'h7F : seg_decode(cur_digit);
      dp_next   = (idx_reg != 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seg_reg <= 7'h7F;
         an_reg  <= 4'hF;
         dp_reg  <= 1'b1;
      end else begin
         seg_reg <= seg_next;
         an_reg  <= an_next;
         dp_reg  <= dp_next;
      end
   end

   assign seg = seg_reg;
   assign an  = an_reg;
   assign dp  = dp_reg;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with a 4-cycle refresh slot.
// Expected patterns are hand-written constants for each scan slot.
module tb_stopwatch_display;

   logic       clk = 1'b0;
   logic       rst;
   logic       clk_blink;
   logic       adj;
   logic       sel;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   stopwatch_display #(
      .REFRESH_DIV(4),
      .CNT_W      (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_blink(clk_blink),
      .adj      (adj),
      .sel      (sel),
      .min_tens (min_tens),
      .min_ones (min_ones),
      .sec_tens (sec_tens),
      .sec_ones (sec_ones),
      .seg      (seg),
      .an       (an),
      .dp       (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   function automatic logic [3:0] an_exp(input int slot);
      case (slot)
         0:       return 4'hE;
         1:       return 4'hD;
         2:       return 4'hB;
         default: return 4'h7;
      endcase
   endfunction

   task automatic check_out(input string tag, input logic [3:0] an_e,
                            input logic [6:0] seg_e, input logic dp_e);
      $display("cyc=%0d %s an=%h seg=%h dp=%b", cyc, tag, an, seg, dp);
      chk($sformatf("%s_an", tag),  {4'h0, an},  {4'h0, an_e});
      chk($sformatf("%s_seg", tag), {1'b0, seg}, {1'b0, seg_e});
      chk($sformatf("%s_dp", tag),  {7'h0, dp},  {7'h0, dp_e});
   endtask

   task automatic check_cycle(input int slot, input logic [6:0] seg_e, input bit blank);
      step();
      check_out($sformatf("slot%0d", slot),
                blank ? 4'hF : an_exp(slot),
                blank ? 7'h7F : seg_e,
                (slot == 2) ? 1'b0 : 1'b1);
   endtask

   task automatic check_slot(input int slot, input logic [6:0] seg_e, input bit blank);
      repeat (4) check_cycle(slot, seg_e, blank);
   endtask

   task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
      check_slot(0, s0, 1'b0);
      check_slot(1, s1, 1'b0);
      check_slot(2, s2, 1'b0);
      check_slot(3, s3, 1'b0);
   endtask

   task automatic set_time(input logic [3:0] mt, input logic [3:0] mo,
                           input logic [3:0] st, input logic [3:0] so);
      min_tens = mt;
      min_ones = mo;
      sec_tens = st;
      sec_ones = so;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      adj       = 1'b0;
      sel       = 1'b0;
      clk_blink = 1'b0;
      set_time(4'd1, 4'd2, 4'd3, 4'd4);

      // Held in reset: display dark.
      repeat (3) begin
         step();
         check_out("reset", 4'hF, 7'h7F, 1'b1);
      end
      rst = 1'b0;

      // First frame shows the zeroed snapshot, then 12:34.
      check_frame(7'h40, 7'h40, 7'h40, 7'h40);
      check_frame(7'h19, 7'h30, 7'h24, 7'h79);
      check_frame(7'h19, 7'h30, 7'h24, 7'h79);

      // Input change while idx=1 must not tear the current frame.
      check_slot(0, 7'h19, 1'b0);
      check_cycle(1, 7'h30, 1'b0);
      set_time(4'd5, 4'd6, 4'd0, 4'd7);
      repeat (3) check_cycle(1, 7'h30, 1'b0);
      check_slot(2, 7'h24, 1'b0);
      check_slot(3, 7'h79, 1'b0);

      // Frame showing 56:07; enter adjust mode during the minutes-tens slot.
      check_slot(0, 7'h78, 1'b0);
      check_slot(1, 7'h40, 1'b0);
      check_slot(2, 7'h02, 1'b0);
      repeat (2) check_cycle(3, 7'h12, 1'b0);
      adj       = 1'b1;
      sel       = 1'b0;
      clk_blink = 1'b1;
      repeat (2) check_cycle(3, 7'h12, 1'b0);

      // Seconds pair blanked, minutes still scanned; blink goes low late in the frame.
      check_slot(0, 7'h78, 1'b1);
      check_slot(1, 7'h40, 1'b1);
      check_slot(2, 7'h02, 1'b0);
      repeat (2) check_cycle(3, 7'h12, 1'b0);
      clk_blink = 1'b0;
      repeat (2) check_cycle(3, 7'h12, 1'b0);

      // blink low: all lit; then sel=1 with blink high blanks the minutes pair.
      check_slot(0, 7'h78, 1'b0);
      repeat (2) check_cycle(1, 7'h40, 1'b0);
      sel       = 1'b1;
      clk_blink = 1'b1;
      repeat (2) check_cycle(1, 7'h40, 1'b0);
      check_slot(2, 7'h02, 1'b1);
      check_slot(3, 7'h12, 1'b1);

      // adj=0 ignores clk_blink; an invalid BCD code is loaded for the next frame.
      adj = 1'b0;
      check_slot(0, 7'h78, 1'b0);
      check_slot(1, 7'h40, 1'b0);
      sec_ones = 4'hB;
      check_slot(2, 7'h02, 1'b0);
      check_slot(3, 7'h12, 1'b0);
      check_frame(7'h3F, 7'h40, 7'h02, 7'h12);

      // Asynchronous reset in the middle of the idx=2 slot.
      check_slot(0, 7'h3F, 1'b0);
      check_slot(1, 7'h40, 1'b0);
      repeat (2) check_cycle(2, 7'h02, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_out("rst_async", 4'hF, 7'h7F, 1'b1);
      step();
      check_out("rst_hold", 4'hF, 7'h7F, 1'b1);
      rst = 1'b0;

      // Scan restarts at idx0 with a full-length slot and a zeroed snapshot.
      check_frame(7'h40, 7'h40, 7'h40, 7'h40);
      check_frame(7'h3F, 7'h40, 7'h02, 7'h12);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
